// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants (FSM states, instruction width, PC step, decode encodings).
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_INC  = 2;

  // Encodings decode also recognises; kept here so both stages agree.
  localparam logic [INSTR_W-1:0] INSTR_NOP  = 16'h0000;
  localparam logic [INSTR_W-1:0] INSTR_HALT = 16'hFFFF;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with push/pop/clear, occupancy count and empty/full flags.
// Latency: a pushed word is visible at head_dat_o on the cycle after the push edge.
// Backpressure: none internally; caller must not push when full (unless popping) nor pop when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state; clear wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // Storage and pointer registers; storage is zeroed so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: holds the fetch PC, issues imem requests, queues returned instructions for decode.
// Latency: imem_rvalid in cycle N -> instr_valid in cycle N+1; flush squashes decode output the same cycle.
// Backpressure: dec_ready=0 holds the queue head; queued+outstanding is capped at QDEPTH, which gates imem_req.
// Optional feature macro FETCH_PERF_EN adds perf_fetched / perf_dropped event counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     QDEPTH   = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  input  logic               dec_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int unsigned     CNT_W   = cnt_width(QDEPTH);
  localparam int unsigned     IQ_W    = PC_W + INSTR_W;
  localparam logic [PC_W-1:0] BOOT_PC = RESET_PC & ~PC_W'(1);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             hs;
  logic             rsp_drop;
  logic             iq_push, iq_pop;
  logic [CNT_W:0]   credits_used;
  logic [PC_W-1:0]  redirect_pc;

  logic [PC_W-1:0]  pcf_head;
  logic [CNT_W-1:0] pcf_count;
  logic             pcf_empty, pcf_full;
  logic [IQ_W-1:0]  iq_head;
  logic [CNT_W-1:0] iq_count;
  logic             iq_empty, iq_full;

  // Every queued entry or in-flight request holds one credit, so the queue can never overflow.
  assign credits_used = {1'b0, iq_count} + {1'b0, outstanding_q};
  assign imem_req     = (state_q != BOOT) && !flush && (credits_used < (CNT_W+1)'(QDEPTH));
  assign imem_addr    = fetch_pc_q;
  assign hs           = imem_req & imem_gnt;

  // Responses for requests issued before a redirect are discarded in order.
  assign rsp_drop     = imem_rvalid & (flush | (drop_cnt_q != '0));
  assign iq_push      = imem_rvalid & ~rsp_drop;

  assign instr_valid  = ~iq_empty & ~flush;
  assign iq_pop       = instr_valid & dec_ready;
  assign instr_out    = iq_head[INSTR_W-1:0];
  assign pc_out       = iq_head[IQ_W-1:INSTR_W];

  assign redirect_pc  = branch_pc & ~PC_W'(1);

  // Addresses of requests still waiting for their response, oldest at head.
  fetch_queue #(.WIDTH(PC_W), .DEPTH(QDEPTH)) u_pc_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (1'b0),
    .push_i     (hs),
    .push_dat_i (fetch_pc_q),
    .pop_i      (imem_rvalid),
    .head_dat_o (pcf_head),
    .count_o    (pcf_count),
    .empty_o    (pcf_empty),
    .full_o     (pcf_full)
  );

  // Right-path {pc, instr} pairs waiting for decode.
  fetch_queue #(.WIDTH(IQ_W), .DEPTH(QDEPTH)) u_instr_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (flush),
    .push_i     (iq_push),
    .push_dat_i ({pcf_head, imem_rdata}),
    .pop_i      (iq_pop),
    .head_dat_o (iq_head),
    .count_o    (iq_count),
    .empty_o    (iq_empty),
    .full_o     (iq_full)
  );

  // Next state for FSM, fetch PC and request/drop counters; a redirect overrides everything.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (hs && !imem_rvalid)      outstanding_d = outstanding_q + 1'b1;
    else if (!hs && imem_rvalid) outstanding_d = outstanding_q - 1'b1;

    if (hs) fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);

    if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Everything still in flight after this cycle belongs to the wrong path.
    if (flush) begin
      fetch_pc_d = redirect_pc;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : RUN;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= BOOT_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;
  logic [31:0] dropped_inc;

  // Discarded responses plus entries thrown away when the queue is cleared by a redirect.
  assign dropped_inc = 32'(rsp_drop) + (flush ? 32'(iq_count) : 32'd0);

  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(iq_pop);
      perf_dropped_q <= perf_dropped_q + dropped_inc;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

  // Memory must only answer requests it accepted; the PC side-FIFO tracks the same population.
  a_rvalid_needs_req : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding_q != '0) && !pcf_empty);
  a_out_matches_fifo : assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_q == pcf_count);
  a_no_overflow      : assert property (@(posedge clk) disable iff (!rst_n)
    (!(hs && pcf_full)) && !(iq_push && iq_full && !iq_pop));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] branch_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        dec_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(16), .QDEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .branch_pc   (branch_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .dec_ready   (dec_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  // Reference model: in-flight requests carry a wrong-path flag; the decode queue is a plain list.
  typedef struct packed { logic [15:0] pc; logic stale; } ost_t;
  typedef struct packed { logic [15:0] pc; logic [15:0] instr; } ent_t;

  ost_t        m_out[$];
  ent_t        m_q[$];
  logic [15:0] m_pc;
  bit          m_boot;
  int unsigned m_fetched, m_dropped;

  logic [15:0] mem_q[$];      // addresses the memory accepted, answered in order
  logic [15:0] hs_log[$];     // DUT request addresses that were granted
  logic [15:0] dec_log[$];    // DUT pc_out values handed to decode
  int          cyc;
  int          first_ival_cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] at(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_out.delete();
    m_q.delete();
    m_pc = 16'h0000;
    m_boot = 1'b1;
    m_fetched = 0;
    m_dropped = 0;
    mem_q.delete();
    hs_log.delete();
    dec_log.delete();
    cyc = 0;
    first_ival_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    branch_pc = 16'h0000;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 16'h0000;
    dec_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_dropped", perf_dropped, 0);
`endif
    rst_n = 1'b1;
  endtask

  // Memory/decode environment for the coming cycle; rvalid only for accepted requests.
  task automatic drive(input bit g, input bit rv_ok, input bit dr);
    imem_gnt    = g;
    dec_ready   = dr;
    imem_rvalid = rv_ok && (mem_q.size() > 0);
    imem_rdata  = imem_rvalid ? mem_fn(mem_q[0]) : 16'($urandom);
  endtask

  // Compare DUT against the model for this cycle, advance the model, then clock.
  task automatic step();
    bit   exp_req, exp_ival, hs_m, pop_m;
    ost_t o;
    #2;
    exp_req  = !m_boot && !flush && (m_q.size() + m_out.size() < 2);
    exp_ival = (m_q.size() != 0) && !flush;
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, exp_ival);
    if (exp_ival) begin
      chk("instr_out", instr_out, m_q[0].instr);
      chk("pc_out", pc_out, m_q[0].pc);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
`endif
    if (imem_req && imem_gnt) hs_log.push_back(imem_addr);
    if (instr_valid && dec_ready) dec_log.push_back(pc_out);
    if (instr_valid && first_ival_cyc < 0) first_ival_cyc = cyc;

    hs_m  = exp_req && imem_gnt;
    pop_m = exp_ival && dec_ready;
    if (pop_m) begin
      void'(m_q.pop_front());
      m_fetched++;
    end
    if (imem_rvalid) begin
      if (m_out.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_without_req: response arrived, model has none outstanding (cycle %0d)", cyc);
      end else begin
        o = m_out.pop_front();
        if (o.stale || flush) m_dropped++;
        else m_q.push_back({o.pc, mem_fn(o.pc)});
      end
    end
    if (flush) begin
      m_dropped += m_q.size();
      m_q.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_pc = branch_pc & 16'hFFFE;
    end else if (hs_m) begin
      m_out.push_back({m_pc, 1'b0});
      m_pc = m_pc + 16'd2;
    end
    m_boot = 1'b0;

    if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (imem_req && imem_gnt) mem_q.push_back(imem_addr);

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming with everything ready.
    do_reset();
    repeat (12) begin drive(1, 1, 1); step(); end
    chk("t1_first_ival_cycle", first_ival_cyc, 3);
    chk("t1_hs0", at(hs_log, 0), 16'h0000);
    chk("t1_hs1", at(hs_log, 1), 16'h0002);
    chk("t1_hs2", at(hs_log, 2), 16'h0004);
    chk("t1_dec0", at(dec_log, 0), 16'h0000);
    chk("t1_dec1", at(dec_log, 1), 16'h0002);
    chk("t1_dec2", at(dec_log, 2), 16'h0004);

    // Decode stalled: credits run out, nothing lost.
    do_reset();
    repeat (7) begin drive(1, 1, 0); step(); end
    chk("t2_req_stalled", imem_req, 0);
    chk("t2_ival_held", instr_valid, 1);
    chk("t2_head_pc", pc_out, 16'h0000);
    chk("t2_hs_count", hs_log.size(), 2);
    repeat (6) begin drive(1, 1, 1); step(); end
    chk("t2_dec0", at(dec_log, 0), 16'h0000);
    chk("t2_dec1", at(dec_log, 1), 16'h0002);

    // Redirect with two requests in flight.
    do_reset();
    repeat (3) begin drive(1, 0, 1); step(); end
    drive(1, 0, 1); flush = 1'b1; branch_pc = 16'h0041; step(); flush = 1'b0;
    repeat (10) begin drive(1, 1, 1); step(); end
    chk("t3_target_addr", at(hs_log, 2), 16'h0040);
    chk("t3_first_dec_pc", at(dec_log, 0), 16'h0040);
`ifdef FETCH_PERF_EN
    chk("t3_perf_dropped", perf_dropped, 2);
    chk("t3_perf_fetched", perf_fetched, dec_log.size());
`endif

    // Redirect in the same cycle as a response and a grant.
    do_reset();
    repeat (3) begin drive(1, 0, 1); step(); end
    drive(1, 1, 1); flush = 1'b1; branch_pc = 16'h1234; step(); flush = 1'b0;
    repeat (10) begin drive(1, 1, 1); step(); end
    chk("t4_target_addr", at(hs_log, 2), 16'h1234);
    chk("t4_first_dec_pc", at(dec_log, 0), 16'h1234);
`ifdef FETCH_PERF_EN
    chk("t4_perf_dropped", perf_dropped, 2);
`endif

    // PC wrap, then asynchronous reset while draining.
    do_reset();
    drive(1, 0, 1); step();
    drive(1, 0, 1); flush = 1'b1; branch_pc = 16'hFFFF; step(); flush = 1'b0;
    repeat (3) begin drive(1, 0, 1); step(); end
    drive(1, 0, 1); flush = 1'b1; branch_pc = 16'h0100; step(); flush = 1'b0;
    drive(0, 0, 1); step();
    chk("t5_hs_wrap0", at(hs_log, 0), 16'hFFFE);
    chk("t5_hs_wrap1", at(hs_log, 1), 16'h0000);
    chk("t5_drain_addr", imem_addr, 16'h0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_req", imem_req, 0);
    chk("t5_async_addr", imem_addr, 16'h0000);
    chk("t5_async_ival", instr_valid, 0);
    chk("t5_async_instr", instr_out, 16'h0000);
    chk("t5_async_pc", pc_out, 16'h0000);

    // Randomised traffic with occasional redirects.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 75);
      flush = ($urandom_range(0, 99) < 5);
      branch_pc = 16'($urandom);
      step();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
